// File: rtl/decode_stage.sv
// RV32I decode stage: latches one fetched instruction, reads its source
// registers for one cycle, then presents the decoded bundle to execute.
module decode_stage (
    input  logic        clk,
    input  logic        reset,
    input  logic        in_valid,
    output logic        in_ready,
    input  logic [31:0] in_instr,
    input  logic [31:0] in_pc,
    output logic [4:0]  rf_read_address_1,
    output logic [4:0]  rf_read_address_2,
    input  logic [31:0] rf_read_data_1,
    input  logic [31:0] rf_read_data_2,
    output logic        out_valid,
    input  logic        out_ready,
    output logic [31:0] out_pc,
    output logic [31:0] out_rs1_value,
    output logic [31:0] out_rs2_value,
    output logic [31:0] out_imm,
    output logic [4:0]  out_rd,
    output logic        out_rd_we,
    output logic [6:0]  out_opcode,
    output logic [2:0]  out_funct3,
    output logic [6:0]  out_funct7,
    output logic        out_illegal
);

    localparam logic [1:0] IDLE  = 2'd0;
    localparam logic [1:0] READ  = 2'd1;
    localparam logic [1:0] VALID = 2'd2;

    localparam logic [6:0] OPC_LUI    = 7'b0110111;
    localparam logic [6:0] OPC_AUIPC  = 7'b0010111;
    localparam logic [6:0] OPC_JAL    = 7'b1101111;
    localparam logic [6:0] OPC_JALR   = 7'b1100111;
    localparam logic [6:0] OPC_BRANCH = 7'b1100011;
    localparam logic [6:0] OPC_LOAD   = 7'b0000011;
    localparam logic [6:0] OPC_STORE  = 7'b0100011;
    localparam logic [6:0] OPC_OPIMM  = 7'b0010011;
    localparam logic [6:0] OPC_OP     = 7'b0110011;

    logic [1:0]  state;
    logic [1:0]  next_state;
    logic        ready_en;
    logic        in_xfer;
    logic        out_xfer;

    // Source-register fields of the latched instruction (the reset NOP has
    // both fields zero, so these reset to zero).
    logic [4:0]  rs1_q;
    logic [4:0]  rs2_q;

    logic [31:0] dec_imm;
    logic        dec_illegal;
    logic        dec_rd_we;

    assign in_xfer  = in_valid & in_ready;
    assign out_xfer = out_valid & out_ready;

    // Handshake outputs decoded from state; in_ready is held low until the
    // first clock edge after reset releases.
    always_comb begin
        in_ready  = 1'b0;
        out_valid = 1'b0;
        case (state)
            IDLE:    in_ready = ready_en;
            VALID: begin
                out_valid = 1'b1;
                in_ready  = ready_en & out_ready;
            end
            default: begin
                in_ready  = 1'b0;
                out_valid = 1'b0;
            end
        endcase
    end

    // Register file addresses come straight from the latched instruction.
    assign rf_read_address_1 = rs1_q;
    assign rf_read_address_2 = rs2_q;

    // Next-state logic: IDLE -> READ on accept, READ -> VALID always,
    // VALID -> READ (pass-through) or IDLE (drain) on output transfer.
    always_comb begin
        next_state = state;
        case (state)
            IDLE: begin
                if (in_xfer) begin
                    next_state = READ;
                end
            end
            READ: next_state = VALID;
            VALID: begin
                if (out_xfer) begin
                    next_state = in_xfer ? READ : IDLE;
                end
            end
            default: next_state = IDLE;
        endcase
    end

    // State register.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            state <= IDLE;
        end else begin
            state <= next_state;
        end
    end

    // Delays in_ready by one edge after reset release.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            ready_en <= 1'b0;
        end else begin
            ready_en <= 1'b1;
        end
    end

    // Immediate / legality / write-enable decode of the incoming instruction.
    always_comb begin
        dec_imm     = 32'h0;
        dec_illegal = 1'b0;
        dec_rd_we   = 1'b0;
        case (in_instr[6:0])
            OPC_JALR, OPC_LOAD, OPC_OPIMM: begin
                dec_imm   = {{20{in_instr[31]}}, in_instr[31:20]};
                dec_rd_we = (in_instr[11:7] != 5'd0);
            end
            OPC_STORE: begin
                dec_imm = {{20{in_instr[31]}}, in_instr[31:25], in_instr[11:7]};
            end
            OPC_BRANCH: begin
                dec_imm = {{19{in_instr[31]}}, in_instr[31], in_instr[7],
                           in_instr[30:25], in_instr[11:8], 1'b0};
            end
            OPC_LUI, OPC_AUIPC: begin
                dec_imm   = {in_instr[31:12], 12'h000};
                dec_rd_we = (in_instr[11:7] != 5'd0);
            end
            OPC_JAL: begin
                dec_imm   = {{11{in_instr[31]}}, in_instr[31], in_instr[19:12],
                             in_instr[20], in_instr[30:21], 1'b0};
                dec_rd_we = (in_instr[11:7] != 5'd0);
            end
            OPC_OP: begin
                dec_imm   = 32'h0;
                dec_rd_we = (in_instr[11:7] != 5'd0);
            end
            default: begin
                dec_illegal = 1'b1;
            end
        endcase
        // Compressed / non-32-bit encodings are never legal here.
        if (in_instr[1:0] != 2'b11) begin
            dec_illegal = 1'b1;
            dec_imm     = 32'h0;
            dec_rd_we   = 1'b0;
        end
    end

    // Decoded fields latch on input transfer; operand values latch at the
    // edge that ends READ.
    always_ff @(posedge clk or posedge reset) begin
        if (reset) begin
            rs1_q         <= 5'd0;
            rs2_q         <= 5'd0;
            out_pc        <= 32'h0;
            out_imm       <= 32'h0;
            out_rd        <= 5'd0;
            out_rd_we     <= 1'b0;
            out_opcode    <= 7'd0;
            out_funct3    <= 3'd0;
            out_funct7    <= 7'd0;
            out_illegal   <= 1'b0;
            out_rs1_value <= 32'h0;
            out_rs2_value <= 32'h0;
        end else begin
            if (in_xfer) begin
                rs1_q       <= in_instr[19:15];
                rs2_q       <= in_instr[24:20];
                out_pc      <= in_pc;
                out_imm     <= dec_imm;
                out_rd      <= in_instr[11:7];
                out_rd_we   <= dec_rd_we;
                out_opcode  <= in_instr[6:0];
                out_funct3  <= in_instr[14:12];
                out_funct7  <= in_instr[31:25];
                out_illegal <= dec_illegal;
            end
            if (state == READ) begin
                out_rs1_value <= rf_read_data_1;
                out_rs2_value <= rf_read_data_2;
            end
        end
    end

endmodule

// File: tb/tb_decode_stage.sv
// Self-checking bench for decode_stage: scoreboard of expected bundles plus
// per-scenario timing and field checks.
module tb_decode_stage;

    typedef struct packed {
        logic [31:0] pc;
        logic [31:0] rs1v;
        logic [31:0] rs2v;
        logic [31:0] imm;
        logic [4:0]  rd;
        logic        rd_we;
        logic [6:0]  opcode;
        logic [2:0]  funct3;
        logic [6:0]  funct7;
        logic        illegal;
    } bundle_t;

    logic        clk;
    logic        reset;
    logic        in_valid;
    logic        in_ready;
    logic [31:0] in_instr;
    logic [31:0] in_pc;
    logic [4:0]  rf_read_address_1;
    logic [4:0]  rf_read_address_2;
    logic [31:0] rf_read_data_1;
    logic [31:0] rf_read_data_2;
    logic        out_valid;
    logic        out_ready;
    logic [31:0] out_pc;
    logic [31:0] out_rs1_value;
    logic [31:0] out_rs2_value;
    logic [31:0] out_imm;
    logic [4:0]  out_rd;
    logic        out_rd_we;
    logic [6:0]  out_opcode;
    logic [2:0]  out_funct3;
    logic [6:0]  out_funct7;
    logic        out_illegal;

    int checks = 0;
    int errors = 0;
    int cyc = 0;
    bundle_t sb_q[$];
    bundle_t mon_act;
    bundle_t mon_exp;
    logic [31:0] rf [32];

    decode_stage dut (
        .clk(clk),
        .reset(reset),
        .in_valid(in_valid),
        .in_ready(in_ready),
        .in_instr(in_instr),
        .in_pc(in_pc),
        .rf_read_address_1(rf_read_address_1),
        .rf_read_address_2(rf_read_address_2),
        .rf_read_data_1(rf_read_data_1),
        .rf_read_data_2(rf_read_data_2),
        .out_valid(out_valid),
        .out_ready(out_ready),
        .out_pc(out_pc),
        .out_rs1_value(out_rs1_value),
        .out_rs2_value(out_rs2_value),
        .out_imm(out_imm),
        .out_rd(out_rd),
        .out_rd_we(out_rd_we),
        .out_opcode(out_opcode),
        .out_funct3(out_funct3),
        .out_funct7(out_funct7),
        .out_illegal(out_illegal)
    );

    assign rf_read_data_1 = rf[rf_read_address_1];
    assign rf_read_data_2 = rf[rf_read_address_2];

    initial clk = 1'b0;
    always #5 clk = ~clk;
    always @(posedge clk) cyc <= cyc + 1;

    // Reference decode, written from the RV32I encoding tables.
    function automatic bundle_t model(input logic [31:0] i, input logic [31:0] pc);
        bundle_t b;
        logic signed [11:0] imm_i;
        logic signed [11:0] imm_s;
        logic signed [12:0] imm_b;
        logic signed [20:0] imm_j;
        logic writes;
        b.pc     = pc;
        b.rs1v   = rf[i[19:15]];
        b.rs2v   = rf[i[24:20]];
        b.rd     = i[11:7];
        b.opcode = i[6:0];
        b.funct3 = i[14:12];
        b.funct7 = i[31:25];
        b.imm    = 32'h0;
        b.illegal = 1'b0;
        writes   = 1'b0;
        imm_i = i[31:20];
        imm_s = {i[31:25], i[11:7]};
        imm_b = {i[31], i[7], i[30:25], i[11:8], 1'b0};
        imm_j = {i[31], i[19:12], i[20], i[30:21], 1'b0};
        case (i[6:0])
            7'h67, 7'h03, 7'h13: begin b.imm = 32'(imm_i); writes = 1'b1; end
            7'h23: b.imm = 32'(imm_s);
            7'h63: b.imm = 32'(imm_b);
            7'h37, 7'h17: begin b.imm = i & 32'hFFFFF000; writes = 1'b1; end
            7'h6F: begin b.imm = 32'(imm_j); writes = 1'b1; end
            7'h33: writes = 1'b1;
            default: b.illegal = 1'b1;
        endcase
        if (i[1:0] != 2'b11) b.illegal = 1'b1;
        if (b.illegal) begin
            b.imm = 32'h0;
            writes = 1'b0;
        end
        b.rd_we = writes && (i[11:7] != 5'd0);
        return b;
    endfunction

    // Scoreboard: every output transfer must match the oldest accepted instruction.
    always @(negedge clk) begin
        if (!reset && out_valid && out_ready) begin
            checks++;
            mon_act = {out_pc, out_rs1_value, out_rs2_value, out_imm, out_rd,
                       out_rd_we, out_opcode, out_funct3, out_funct7, out_illegal};
            if (sb_q.size() == 0) begin
                errors++;
                $display("FAIL scoreboard: unexpected output pc=%h", out_pc);
            end else begin
                mon_exp = sb_q.pop_front();
                if (mon_act !== mon_exp) begin
                    errors++;
                    $display("FAIL scoreboard: got %h expected %h", mon_act, mon_exp);
                end
            end
        end
    end

    // Present one instruction from the drive point and wait (bounded) for acceptance.
    task automatic issue(input logic [31:0] i, input logic [31:0] pc);
        int n;
        n = 0;
        in_valid = 1'b1;
        in_instr = i;
        in_pc    = pc;
        @(negedge clk);
        while (!in_ready && n < 50) begin
            @(negedge clk);
            n++;
        end
        if (!in_ready) begin
            checks++;
            errors++;
            $display("FAIL issue_timeout: in_ready=%b expected 1 for instr %h", in_ready, i);
        end else begin
            sb_q.push_back(model(i, pc));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
    endtask

    task automatic test_reset;
        repeat (2) @(posedge clk);
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL reset_handshake: in_ready/out_valid=%b expected 00", {in_ready, out_valid});
        end
        checks++;
        if ({out_pc, out_imm, out_rs1_value, out_opcode, out_rd, out_illegal} !== '0) begin
            errors++;
            $display("FAIL reset_data: pc=%h imm=%h rs1=%h op=%h expected all 0",
                     out_pc, out_imm, out_rs1_value, out_opcode);
        end
        checks++;
        if ({rf_read_address_1, rf_read_address_2} !== 10'd0) begin
            errors++;
            $display("FAIL reset_rfaddr: %h/%h expected 0/0", rf_read_address_1, rf_read_address_2);
        end
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b0) begin
            errors++;
            $display("FAIL reset_release_early: in_ready=%b expected 0", in_ready);
        end
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL reset_release: in_ready=%b expected 1", in_ready);
        end
    endtask

    task automatic test_addi;
        out_ready = 1'b1;
        issue(32'hFFF08293, 32'h0000_0100);
        @(negedge clk);
        checks++;
        if ({out_valid, rf_read_address_1} !== {1'b0, 5'd1}) begin
            errors++;
            $display("FAIL addi_read: out_valid=%b rs1addr=%0d expected 0/1", out_valid, rf_read_address_1);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL addi_latency: out_valid=%b expected 1", out_valid);
        end
        checks++;
        if ({out_imm, out_rs1_value, out_rd, out_rd_we} !== {32'hFFFFFFFF, 32'd7, 5'd5, 1'b1}) begin
            errors++;
            $display("FAIL addi_fields: imm=%h rs1=%h rd=%0d we=%b expected ffffffff/7/5/1",
                     out_imm, out_rs1_value, out_rd, out_rd_we);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_store;
        out_ready = 1'b1;
        issue(32'h0021A423, 32'h0000_0104);
        @(negedge clk);
        checks++;
        if ({rf_read_address_1, rf_read_address_2} !== {5'd3, 5'd2}) begin
            errors++;
            $display("FAIL sw_rfaddr: %0d/%0d expected 3/2", rf_read_address_1, rf_read_address_2);
        end
        @(negedge clk);
        checks++;
        if ({out_valid, out_imm, out_rd_we, out_illegal} !== {1'b1, 32'd8, 1'b0, 1'b0}) begin
            errors++;
            $display("FAIL sw_fields: valid=%b imm=%h we=%b ill=%b expected 1/8/0/0",
                     out_valid, out_imm, out_rd_we, out_illegal);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_stall;
        bundle_t ea;
        bundle_t act;
        ea = model(32'h002081B3, 32'h0000_0200);
        out_ready = 1'b0;
        issue(32'h002081B3, 32'h0000_0200);
        in_valid = 1'b1;
        in_instr = 32'h00510393;
        in_pc    = 32'h0000_0204;
        @(negedge clk);
        checks++;
        if ({in_ready, out_valid} !== 2'b00) begin
            errors++;
            $display("FAIL stall_read_ignore: in_ready/out_valid=%b expected 00", {in_ready, out_valid});
        end
        for (int c = 0; c < 5; c++) begin
            @(negedge clk);
            act = {out_pc, out_rs1_value, out_rs2_value, out_imm, out_rd,
                   out_rd_we, out_opcode, out_funct3, out_funct7, out_illegal};
            checks++;
            if ({out_valid, in_ready, act} !== {1'b1, 1'b0, ea}) begin
                errors++;
                $display("FAIL stall_hold[%0d]: valid=%b ready=%b got %h expected %h",
                         c, out_valid, in_ready, act, ea);
            end
        end
        @(posedge clk);
        #1;
        out_ready = 1'b1;
        @(negedge clk);
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL stall_release: in_ready=%b expected 1", in_ready);
        end else begin
            sb_q.push_back(model(32'h00510393, 32'h0000_0204));
        end
        @(posedge clk);
        #1;
        in_valid = 1'b0;
        @(negedge clk);
        checks++;
        if ({out_valid, rf_read_address_1} !== {1'b0, 5'd2}) begin
            errors++;
            $display("FAIL stall_nobubble_read: valid=%b rs1addr=%0d expected 0/2", out_valid, rf_read_address_1);
        end
        @(negedge clk);
        checks++;
        if (out_valid !== 1'b1) begin
            errors++;
            $display("FAIL stall_nobubble_valid: out_valid=%b expected 1", out_valid);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_illegal;
        logic [31:0] ins [3];
        logic [31:0] eimm [3];
        logic        eill [3];
        ins[0] = 32'hFFFFFFFF; eimm[0] = 32'h0;        eill[0] = 1'b1;
        ins[1] = 32'h12345037; eimm[1] = 32'h12345000; eill[1] = 1'b0;
        ins[2] = 32'h00500090; eimm[2] = 32'h0;        eill[2] = 1'b1;
        out_ready = 1'b1;
        for (int k = 0; k < 3; k++) begin
            issue(ins[k], 32'h0000_0300 + 32'(k * 4));
            @(negedge clk);
            @(negedge clk);
            checks++;
            if ({out_valid, out_illegal, out_imm, out_rd_we} !== {1'b1, eill[k], eimm[k], 1'b0}) begin
                errors++;
                $display("FAIL illegal_%0d: valid=%b ill=%b imm=%h we=%b expected 1/%b/%h/0",
                         k, out_valid, out_illegal, out_imm, out_rd_we, eill[k], eimm[k]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_jal_beq;
        logic [31:0] ins [2];
        logic [31:0] eimm [2];
        logic        ewe [2];
        ins[0] = 32'hFFDFF0EF; eimm[0] = 32'hFFFFFFFC; ewe[0] = 1'b1;
        ins[1] = 32'hFE000CE3; eimm[1] = 32'hFFFFFFF8; ewe[1] = 1'b0;
        out_ready = 1'b1;
        for (int k = 0; k < 2; k++) begin
            issue(ins[k], 32'h0000_0400 + 32'(k * 4));
            @(negedge clk);
            @(negedge clk);
            checks++;
            if ({out_valid, out_imm, out_rd_we} !== {1'b1, eimm[k], ewe[k]}) begin
                errors++;
                $display("FAIL jump_branch_%0d: valid=%b imm=%h we=%b expected 1/%h/%b",
                         k, out_valid, out_imm, out_rd_we, eimm[k], ewe[k]);
            end
            @(posedge clk);
            #1;
        end
    endtask

    task automatic test_reset_mid;
        out_ready = 1'b1;
        issue(32'h00C58613, 32'h0000_0500);
        #2;
        reset = 1'b1;
        #1;
        checks++;
        if ({out_valid, in_ready} !== 2'b00) begin
            errors++;
            $display("FAIL midreset_handshake: valid/ready=%b expected 00", {out_valid, in_ready});
        end
        checks++;
        if ({out_pc, out_imm, out_opcode, rf_read_address_1, rf_read_address_2} !== '0) begin
            errors++;
            $display("FAIL midreset_data: pc=%h imm=%h op=%h rs1addr=%0d expected 0",
                     out_pc, out_imm, out_opcode, rf_read_address_1);
        end
        sb_q.delete();
        @(posedge clk);
        #1;
        reset = 1'b0;
        @(posedge clk);
        #1;
        checks++;
        if (in_ready !== 1'b1) begin
            errors++;
            $display("FAIL midreset_recover: in_ready=%b expected 1", in_ready);
        end
        issue(32'h40208533, 32'h0000_0600);
        @(negedge clk);
        @(negedge clk);
        checks++;
        if ({out_valid, out_pc} !== {1'b1, 32'h0000_0600}) begin
            errors++;
            $display("FAIL midreset_accept: valid=%b pc=%h expected 1/00000600", out_valid, out_pc);
        end
        @(posedge clk);
        #1;
    endtask

    task automatic test_back_to_back;
        logic [6:0]  ops [10];
        logic [31:0] list [16];
        int first_cyc;
        int last_cyc;
        int n;
        ops[0] = 7'h37; ops[1] = 7'h17; ops[2] = 7'h6F; ops[3] = 7'h67; ops[4] = 7'h63;
        ops[5] = 7'h03; ops[6] = 7'h23; ops[7] = 7'h13; ops[8] = 7'h33; ops[9] = 7'h0B;
        for (int k = 0; k < 16; k++) begin
            if (k < 12) list[k] = {$urandom()} & 32'hFFFFFF80 | 32'(ops[k % 10]);
            else        list[k] = $urandom();
        end
        first_cyc = 0;
        last_cyc  = 0;
        out_ready = 1'b1;
        in_valid  = 1'b1;
        for (int k = 0; k < 16; k++) begin
            in_instr = list[k];
            in_pc    = 32'h0000_1000 + 32'(k * 4);
            n = 0;
            @(negedge clk);
            while (!in_ready && n < 20) begin
                @(negedge clk);
                n++;
            end
            if (!in_ready) begin
                checks++;
                errors++;
                $display("FAIL b2b_accept_timeout: in_ready=%b expected 1 at %0d", in_ready, k);
            end else begin
                sb_q.push_back(model(list[k], 32'h0000_1000 + 32'(k * 4)));
                if (k == 0) first_cyc = cyc;
                last_cyc = cyc;
            end
            @(posedge clk);
            #1;
        end
        in_valid = 1'b0;
        checks++;
        if (last_cyc - first_cyc !== 30) begin
            errors++;
            $display("FAIL b2b_throughput: span=%0d cycles expected 30", last_cyc - first_cyc);
        end
        n = 0;
        while (sb_q.size() != 0 && n < 20) begin
            @(posedge clk);
            n++;
        end
        #1;
        checks++;
        if (sb_q.size() !== 0) begin
            errors++;
            $display("FAIL b2b_drain: %0d outstanding expected 0", sb_q.size());
        end
    endtask

    initial begin
        reset     = 1'b1;
        in_valid  = 1'b0;
        in_instr  = 32'h0;
        in_pc     = 32'h0;
        out_ready = 1'b0;
        for (int k = 0; k < 32; k++) rf[k] = (32'(k) * 32'h01010101) ^ 32'h5A000000;
        rf[0] = 32'h0;
        rf[1] = 32'd7;
        test_reset();
        test_addi();
        test_store();
        test_stall();
        test_illegal();
        test_jal_beq();
        test_reset_mid();
        test_back_to_back();
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end

endmodule
